// File: rtl/commit_unit_if.sv
// Commit-bus interface: one ROB entry per cycle, presented by the ROB head
// logic (master) to the commit unit (slave).
interface commit_unit_if #(
    parameter int WIDTH   = 31,
    parameter int CONTROL = 5,
    parameter int INDEX   = 7,
    parameter int ROB     = 2
);
    logic               validCommit;
    logic [WIDTH:0]     result;
    logic [WIDTH:0]     destCommit;
    logic [WIDTH:0]     targetAddress;
    logic [WIDTH:0]     oldPC;
    logic [WIDTH:0]     statusSnap;
    logic [3:0]         commitInfo;     // {regWrite, memWrite, jump, branch}
    logic [CONTROL:0]   controlFlow;    // {isControl, nextState[1:0], writeBTB, takenBranch, reset}
    logic [INDEX:0]     previousIndex;
    logic [ROB:0]       commitRob;

    modport master (
        output validCommit, result, destCommit, targetAddress, oldPC, statusSnap,
               commitInfo, controlFlow, previousIndex, commitRob
    );

    modport slave (
        input  validCommit, result, destCommit, targetAddress, oldPC, statusSnap,
               commitInfo, controlFlow, previousIndex, commitRob
    );
endinterface

// File: rtl/commit_unit.sv
// Commit unit: retires one ROB entry per cycle into the register file, store
// buffer, BTB and PHT; on a misprediction it issues a one-cycle recovery
// (redirect/cpuReset/status restore) followed by RECOVER freeze cycles.
// All outputs are registered. Optional macro COMMIT_PERF_EN adds the
// retireCount/flushCount performance counters.
module commit_unit #(
    parameter int WIDTH   = 31,
    parameter int CONTROL = 5,
    parameter int INDEX   = 7,
    parameter int ROB     = 2,
    parameter int RECOVER = 2
) (
    input  logic             clk,
    input  logic             globalResetN,
    commit_unit_if.slave     bus,
    output logic             rfWrite,
    output logic [4:0]       rfAddr,
    output logic [WIDTH:0]   rfData,
    output logic             storeCommit,
    output logic [ROB:0]     storeRob,
    output logic             btbWrite,
    output logic [WIDTH:0]   btbPC,
    output logic [WIDTH:0]   btbTarget,
    output logic             phtWrite,
    output logic [INDEX:0]   phtIndex,
    output logic [1:0]       phtState,
    output logic             phtTaken,
    output logic             redirect,
    output logic [WIDTH:0]   redirectPC,
    output logic             cpuReset,
    output logic             priorCommit,
    output logic [ROB:0]     reset_ptr,
    output logic             statusRestore,
    output logic [WIDTH:0]   statusOut,
    output logic             freeze
`ifdef COMMIT_PERF_EN
    ,
    output logic [31:0]      retireCount,
    output logic [15:0]      flushCount
`endif
);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        HOLD
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(RECOVER);

    state_t         state;
    state_t         state_next;
    logic [3:0]     hold_cnt;
    logic [3:0]     hold_cnt_next;

    logic           accept;
    logic           take_flush;
    logic           rf_we;
    logic           st_we;
    logic           btb_we;
    logic           pht_we;
    logic           flushing;
    logic           frozen;

    logic [WIDTH:0] lat_target;
    logic [ROB:0]   lat_rob;
    logic [WIDTH:0] lat_status;

    // Fields of the commit bus that this block does not consume.
    logic           unused_bits;
    assign unused_bits = ^{bus.destCommit[WIDTH:5], bus.commitInfo[1]};

    // Next-state logic and next values for every registered output.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        accept        = 1'b0;
        take_flush    = 1'b0;
        unique case (state)
            RUN: begin
                accept     = bus.validCommit;
                take_flush = bus.validCommit & bus.controlFlow[0];
                if (take_flush) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next    = HOLD;
                hold_cnt_next = HOLD_LOAD;
            end
            HOLD: begin
                if (hold_cnt != 4'd0) begin
                    hold_cnt_next = hold_cnt - 4'd1;
                end
                if (hold_cnt <= 4'd1) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
        rf_we    = accept & bus.commitInfo[3] & (bus.destCommit[4:0] != 5'd0);
        st_we    = accept & bus.commitInfo[2];
        btb_we   = accept & bus.controlFlow[5] & bus.controlFlow[2];
        pht_we   = accept & bus.commitInfo[0];
        flushing = (state == FLUSH);
        frozen   = (state != RUN);
    end

    // FSM state and hold counter.
    always_ff @(posedge clk or negedge globalResetN) begin
        if (!globalResetN) begin
            state    <= RUN;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // Recovery context captured from the mispredicting entry.
    always_ff @(posedge clk or negedge globalResetN) begin
        if (!globalResetN) begin
            lat_target <= '0;
            lat_rob    <= '0;
            lat_status <= '0;
        end else if (take_flush) begin
            lat_target <= bus.targetAddress;
            lat_rob    <= bus.commitRob;
            lat_status <= bus.statusSnap;
        end
    end

    // Registered outputs: pulses every cycle, data only when its pulse fires.
    always_ff @(posedge clk or negedge globalResetN) begin
        if (!globalResetN) begin
            rfWrite       <= 1'b0;
            rfAddr        <= '0;
            rfData        <= '0;
            storeCommit   <= 1'b0;
            storeRob      <= '0;
            btbWrite      <= 1'b0;
            btbPC         <= '0;
            btbTarget     <= '0;
            phtWrite      <= 1'b0;
            phtIndex      <= '0;
            phtState      <= '0;
            phtTaken      <= 1'b0;
            redirect      <= 1'b0;
            redirectPC    <= '0;
            cpuReset      <= 1'b0;
            priorCommit   <= 1'b0;
            reset_ptr     <= '0;
            statusRestore <= 1'b0;
            statusOut     <= '0;
            freeze        <= 1'b0;
        end else begin
            rfWrite       <= rf_we;
            storeCommit   <= st_we;
            btbWrite      <= btb_we;
            phtWrite      <= pht_we;
            redirect      <= flushing;
            cpuReset      <= flushing;
            priorCommit   <= flushing;
            statusRestore <= flushing;
            freeze        <= frozen;
            if (rf_we) begin
                rfAddr <= bus.destCommit[4:0];
                rfData <= bus.result;
            end
            if (st_we) begin
                storeRob <= bus.commitRob;
            end
            if (btb_we) begin
                btbPC     <= bus.oldPC;
                btbTarget <= bus.targetAddress;
            end
            if (pht_we) begin
                phtIndex <= bus.previousIndex;
                phtState <= bus.controlFlow[4:3];
                phtTaken <= bus.controlFlow[1];
            end
            if (flushing) begin
                redirectPC <= lat_target;
                reset_ptr  <= lat_rob;
                statusOut  <= lat_status;
            end
        end
    end

`ifdef COMMIT_PERF_EN
    // Free-running retire and flush counters; both wrap.
    always_ff @(posedge clk or negedge globalResetN) begin
        if (!globalResetN) begin
            retireCount <= '0;
            flushCount  <= '0;
        end else begin
            if (accept) begin
                retireCount <= retireCount + 32'd1;
            end
            if (take_flush) begin
                flushCount <= flushCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 Parameter WIDTH, default 31: data/address MSB index; datapaths are WIDTH+1 bits wide.
REQ-002 Parameter CONTROL, default 5: controlFlow MSB.
REQ-003 Parameter INDEX, default 7: gshare index MSB.
REQ-004 Parameter ROB, default 2: ROB pointer MSB.
REQ-005 Parameter RECOVER, default 2: recovery hold cycles, legal range 1..15.
REQ-006 clk  in  1  sole clock; all state updates on its posedge.
REQ-007 globalResetN  in  1  asynchronous, active-low reset.
REQ-008 validCommit  in  1  commit-bus entry valid this cycle.
REQ-009 result, destCommit, targetAddress, oldPC, statusSnap  in  WIDTH+1 each  commit-bus payload; destCommit[4:0] is the architectural register.
REQ-010 commitInfo  in  4  {regWrite,memWrite,jump,branch}.
REQ-011 controlFlow  in  CONTROL+1  {isControl,nextState[1:0],writeBTB,takenBranch,reset}.
REQ-012 previousIndex  in  INDEX+1; commitRob  in  ROB+1.
REQ-013 rfWrite  out  1; rfAddr  out  5; rfData  out  WIDTH+1: register-file write port.
REQ-014 storeCommit  out  1; storeRob  out  ROB+1: release of a buffered store.
REQ-015 btbWrite  out  1; btbPC, btbTarget  out  WIDTH+1 each.
REQ-016 phtWrite  out  1; phtIndex  out  INDEX+1; phtState  out  2; phtTaken  out  1.
REQ-017 redirect  out  1; redirectPC  out  WIDTH+1: fetch redirect.
REQ-018 cpuReset, priorCommit  out  1 each; reset_ptr  out  ROB+1; statusRestore  out  1; statusOut  out  WIDTH+1.
REQ-019 freeze  out  1: stalls rename/ROB allocation.

Function
REQ-020 All outputs SHALL be registered; a valid commit in cycle N SHALL produce its outputs in cycle N+1.
REQ-021 FSM states SHALL be RUN, FLUSH and HOLD.
REQ-022 In RUN, when validCommit is 1 and commitInfo.regWrite is 1 and destCommit[4:0] is not 0, the block SHALL pulse rfWrite for one cycle with rfAddr=destCommit[4:0] and rfData=result.
REQ-023 In RUN, when validCommit is 1 and commitInfo.memWrite is 1, the block SHALL pulse storeCommit with storeRob=commitRob.
REQ-024 In RUN, when validCommit is 1 and controlFlow.isControl is 1 and writeBTB is 1, the block SHALL pulse btbWrite with btbPC=oldPC and btbTarget=targetAddress.
REQ-025 In RUN, when validCommit is 1 and commitInfo.branch is 1, the block SHALL pulse phtWrite with phtIndex=previousIndex, phtState=nextState and phtTaken=takenBranch.
REQ-026 In RUN, when validCommit is 1 and controlFlow.reset is 1 (misprediction), the block SHALL perform REQ-022..025 for that entry and enter FLUSH.
REQ-027 In FLUSH (exactly 1 cycle), the block SHALL assert redirect=1, redirectPC=targetAddress latched at the mispredicting commit, cpuReset=1, priorCommit=1, reset_ptr=latched commitRob, statusRestore=1, statusOut=latched statusSnap and freeze=1, then enter HOLD.
REQ-028 HOLD SHALL last RECOVER cycles with freeze=1 and all pulse outputs 0, then the FSM SHALL return to RUN.
REQ-029 validCommit received in FLUSH or HOLD SHALL be ignored: no architectural write.
REQ-030 When validCommit is 0, every pulse output SHALL be 0 in the following cycle; data outputs SHALL hold their values.
REQ-031 The HOLD counter SHALL be 4 bits wide and SHALL count down with no wrap.
REQ-032 reset_ptr SHALL be passed through unmodified; ROB pointer wrap is the consumer's concern.

Reset
REQ-033 While globalResetN is 0, the FSM SHALL be RUN and every output and internal register SHALL be 0, immediately and independent of clk.
REQ-034 Reset asserted during FLUSH or HOLD SHALL abort recovery, leaving no redirect or cpuReset pulse after release.
REQ-035 The first commit SHALL be accepted on the first posedge after globalResetN deasserts.

Configuration
REQ-036 Macro COMMIT_PERF_EN: when defined, the block SHALL add outputs retireCount (32 bits) and flushCount (16 bits).
REQ-037 Under COMMIT_PERF_EN, retireCount SHALL increment per accepted commit and flushCount SHALL increment per FLUSH entry; both SHALL wrap and reset to 0.
REQ-038 When COMMIT_PERF_EN is undefined, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-039 Scenario: commit regWrite=1, destCommit=5, result=0xDEADBEEF -> next cycle rfWrite=1, rfAddr=5, rfData=0xDEADBEEF; one cycle later rfWrite=0.
REQ-040 Scenario: commit regWrite=1, destCommit=0 -> rfWrite stays 0.
REQ-041 Scenario: branch commit reset=1, commitRob=3, targetAddress=0x100, RECOVER=2 -> N+1 rfWrite/phtWrite as applicable; N+2 redirect=1, redirectPC=0x100, cpuReset=1, reset_ptr=3; freeze=1 for N+2..N+4; RUN at N+5.
REQ-042 Scenario: validCommit with memWrite=1 during HOLD -> storeCommit stays 0.
REQ-043 Scenario: globalResetN driven low mid-HOLD -> all outputs 0 asynchronously; no redirect pulse after release.
REQ-044 Scenario (COMMIT_PERF_EN defined): 10 commits including 1 misprediction -> retireCount=10, flushCount=1.
